// File: rtl/mem_io_arbiter_pkg.sv
// mem_io_pkg: shared types and constants for the memory/IO port arbiter.
//   state_e          arbiter FSM states
//   IO_PAGE_DEFAULT  addr[31:16] value that selects IO space
//   IO_*             memory-mapped IO register addresses
//   REQ_CPU/REQ_LDR  requester ids (also bit positions in request vectors)
//   is_io()          IO-page decode helper
package mem_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam logic [15:0] IO_PAGE_DEFAULT = 16'hFFFF;

    localparam logic [31:0] IO_LED0   = 32'hFFFF_0000;
    localparam logic [31:0] IO_LED1   = 32'hFFFF_0004;
    localparam logic [31:0] IO_SW0    = 32'hFFFF_0008;
    localparam logic [31:0] IO_SW1    = 32'hFFFF_000C;
    localparam logic [31:0] IO_BTN_LO = 32'hFFFF_0010;
    localparam logic [31:0] IO_BTN_HI = 32'hFFFF_001C;
    localparam logic [31:0] IO_SEG    = 32'hFFFF_0020;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    function automatic logic is_io(input logic [15:0] page, input logic [15:0] io_page);
        return page == io_page;
    endfunction

endpackage

// File: rtl/mem_io_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker.
//   clk_i, rst_i  clock, async active-high reset
//   req_i[1:0]    eligible requests (bit REQ_CPU, bit REQ_LDR)
//   upd_i         commit the current pick as the last grant
//   gnt_o[1:0]    one-hot pick (combinational), zero when no request
// The pointer remembers the last granted requester; on a tie the other one
// wins. Reset points at the loader so the CPU wins the first tie.
module rr_arb2
    import mem_io_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_q == REQ_LDR) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= REQ_LDR;
        end else if (upd_i && (|gnt_o)) begin
            last_q <= gnt_o[REQ_LDR];
        end
    end

endmodule

// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter: shares the data-memory / memory-mapped-IO port between the
// CPU load/store stage and the UART loader.
//   clk, rst                 clock, async active-high reset
//   ldr_mode                 loader owns the port, CPU requests ignored
//   cpu_* / ldr_*            requester side: req/we/addr/wdata in,
//                            gnt/rvalid pulses and held rdata out
//   MemRead/MemWrite/ioRead/ioWrite, addr_out, wdata_out, rdata_in
//                            memory/IO unit side
//   busy                     FSM not idle
// IDLE arbitrates, ACCESS issues the strobe (gnt pulses here), reads then sit
// in HOLD for RD_LAT cycles. Read data is captured on the last strobe cycle
// and returned with rvalid the following cycle, when the FSM is already IDLE.
module mem_io_arbiter
    import mem_io_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int          RD_LAT  = 1,
    parameter logic [15:0] IO_PAGE = IO_PAGE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ldr_mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              ioRead,
    output logic              ioWrite,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] wdata_out,
    input  logic [DATA_W-1:0] rdata_in,
    output logic              busy
);

    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic              owner_q, we_q;
    logic              mrd_q, mwr_q, iord_q, iowr_q;
    logic              cpu_gnt_q, ldr_gnt_q, cpu_rv_q, ldr_rv_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, cpu_rdata_q, ldr_rdata_q;

    logic [1:0]        elig, pick;
    logic              sel_we, sel_io, rd_done;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Only IDLE arbitrates; the pointer moves only when a grant is taken.
    assign elig[REQ_CPU] = cpu_req && !ldr_mode;
    assign elig[REQ_LDR] = ldr_req;

    rr_arb2 u_arb (
        .clk_i (clk),
        .rst_i (rst),
        .req_i (elig),
        .upd_i (state_q == IDLE),
        .gnt_o (pick)
    );

    assign sel_we    = pick[REQ_LDR] ? ldr_we    : cpu_we;
    assign sel_addr  = pick[REQ_LDR] ? ldr_addr  : cpu_addr;
    assign sel_wdata = pick[REQ_LDR] ? ldr_wdata : cpu_wdata;
    assign sel_io    = is_io(sel_addr[ADDR_W-1 -: 16], IO_PAGE);

    // Last cycle a read strobe is high: sample rdata_in at its end.
    assign rd_done = !we_q &&
                     (((state_q == ACCESS) && (RD_LAT_C == 3'd0)) ||
                      ((state_q == HOLD) && (cnt_q == RD_LAT_C)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= REQ_CPU;
            we_q        <= 1'b0;
            mrd_q       <= 1'b0;
            mwr_q       <= 1'b0;
            iord_q      <= 1'b0;
            iowr_q      <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            ldr_gnt_q   <= 1'b0;
            cpu_rv_q    <= 1'b0;
            ldr_rv_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            cpu_gnt_q <= 1'b0;
            ldr_gnt_q <= 1'b0;
            cpu_rv_q  <= 1'b0;
            ldr_rv_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|pick) begin
                        state_q   <= ACCESS;
                        cnt_q     <= '0;
                        owner_q   <= pick[REQ_LDR];
                        we_q      <= sel_we;
                        addr_q    <= sel_addr;
                        wdata_q   <= sel_wdata;
                        mrd_q     <= !sel_we && !sel_io;
                        mwr_q     <=  sel_we && !sel_io;
                        iord_q    <= !sel_we &&  sel_io;
                        iowr_q    <=  sel_we &&  sel_io;
                        cpu_gnt_q <= pick[REQ_CPU];
                        ldr_gnt_q <= pick[REQ_LDR];
                    end
                end
                ACCESS: begin
                    if (we_q || rd_done) begin
                        state_q <= IDLE;
                        {mrd_q, mwr_q, iord_q, iowr_q} <= '0;
                    end else begin
                        state_q <= HOLD;
                        cnt_q   <= 3'd1;
                    end
                end
                HOLD: begin
                    if (rd_done) begin
                        state_q <= IDLE;
                        {mrd_q, mwr_q, iord_q, iowr_q} <= '0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    {mrd_q, mwr_q, iord_q, iowr_q} <= '0;
                end
            endcase
            if (rd_done) begin
                if (owner_q == REQ_LDR) begin
                    ldr_rv_q    <= 1'b1;
                    ldr_rdata_q <= rdata_in;
                end else begin
                    cpu_rv_q    <= 1'b1;
                    cpu_rdata_q <= rdata_in;
                end
            end
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign ldr_gnt    = ldr_gnt_q;
    assign cpu_rvalid = cpu_rv_q;
    assign ldr_rvalid = ldr_rv_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign ldr_rdata  = ldr_rdata_q;
    assign MemRead    = mrd_q;
    assign MemWrite   = mwr_q;
    assign ioRead     = iord_q;
    assign ioWrite    = iowr_q;
    assign addr_out   = addr_q;
    assign wdata_out  = wdata_q;
    assign busy       = (state_q != IDLE);

endmodule
